operand_fetch: RTL and testbench

Register-read and writeback front end of the MIPS pipeline, sitting between decode and execute on one side and `REG_FILE` on the other. It drives both read ports and the write port of the register file. It tracks in-flight destination registers in a 32-bit scoreboard, stalls decode on RAW/WAW hazards, and forwards same-cycle writeback data. Issued operands are held in a one-entry output register with a valid/ready handshake to execute.

---
 rtl/mips_pkg.sv | 14 +
 rtl/reg_scoreboard.sv | 32 +++
 rtl/operand_fetch.sv | 83 ++++++++
 tb/tb_operand_fetch.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file widths, constants and output-stage state type
package mips_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS = 32;
   localparam int DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   typedef enum logic {EMPTY, FULL} out_state_t;
   function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] m;
      m = '0;
      m[addr] = (addr != REG_ZERO);
      return m;
   endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: in-flight destination vector with set-wins update and bypassed hazard queries
module reg_scoreboard
   import mips_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_addr,
   input  logic [REG_ADDR_W-1:0] q_rs,
   input  logic [REG_ADDR_W-1:0] q_rt,
   input  logic [REG_ADDR_W-1:0] q_rd,
   output logic                  hz_rs,
   output logic                  hz_rt,
   output logic                  hz_rd,
   output logic [NUM_REGS-1:0]   busy
);
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   // hazard is a busy nonzero register not being written back this cycle
   always_comb begin
      set_mask = set_en ? reg_mask(set_addr) : '0;
      clr_mask = clr_en ? reg_mask(clr_addr) : '0;
      hz_rs = (q_rs != REG_ZERO) && busy[q_rs] && !(clr_en && clr_addr == q_rs);
      hz_rt = (q_rt != REG_ZERO) && busy[q_rt] && !(clr_en && clr_addr == q_rt);
      hz_rd = (q_rd != REG_ZERO) && busy[q_rd] && !(clr_en && clr_addr == q_rd);
   end
   // clear first, then set, so a same-cycle set on the same register wins
   always_ff @(posedge clk)
      busy <= rst ? '0 : (busy & ~clr_mask) | set_mask;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register read with forwarding, hazard stall and one-entry issue register
module operand_fetch
   import mips_pkg::*;
#(
   parameter int DW = DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   output logic                  id_ready,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_wen,
   output logic                  ex_valid,
   input  logic                  ex_ready,
   output logic [DW-1:0]         ex_a,
   output logic [DW-1:0]         ex_b,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_wen,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DW-1:0]         wb_data,
   output logic [REG_ADDR_W-1:0] rf_r1_addr,
   output logic [REG_ADDR_W-1:0] rf_r2_addr,
   input  logic [DW-1:0]         rf_r1_dout,
   input  logic [DW-1:0]         rf_r2_dout,
   output logic [REG_ADDR_W-1:0] rf_r3_addr,
   output logic [DW-1:0]         rf_r3_din,
   output logic                  rf_r3_wr,
   output logic [NUM_REGS-1:0]   busy
);
   out_state_t state;
   logic hz_rs, hz_rt, hz_rd;
   logic issue;
   logic [DW-1:0] val_a, val_b;
   reg_scoreboard u_sb (
      .clk(clk),
      .rst(rst),
      .set_en(issue && id_wen),
      .set_addr(id_rd),
      .clr_en(wb_valid),
      .clr_addr(wb_addr),
      .q_rs(id_rs),
      .q_rt(id_rt),
      .q_rd(id_rd),
      .hz_rs(hz_rs),
      .hz_rt(hz_rt),
      .hz_rd(hz_rd),
      .busy(busy)
   );
   assign rf_r1_addr = id_rs;
   assign rf_r2_addr = id_rt;
   assign rf_r3_addr = wb_addr;
   assign rf_r3_din = wb_data;
   assign rf_r3_wr = wb_valid && wb_addr != REG_ZERO;
   assign ex_valid = state == FULL;
   // operand selection: r0 reads zero, same-cycle writeback beats the register file
   always_comb begin
      val_a = id_rs == REG_ZERO ? '0 : (wb_valid && wb_addr == id_rs) ? wb_data : rf_r1_dout;
      val_b = id_rt == REG_ZERO ? '0 : (wb_valid && wb_addr == id_rt) ? wb_data : rf_r2_dout;
      id_ready = !rst && !hz_rs && !hz_rt && !(id_wen && hz_rd) && (!ex_valid || ex_ready);
      issue = id_valid && id_ready;
   end
   // output stage: load on issue, drain on ex_ready, hold under backpressure
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         ex_a <= '0;
         ex_b <= '0;
         ex_rd <= '0;
         ex_wen <= 1'b0;
      end else if (issue) begin
         state <= FULL;
         ex_a <= val_a;
         ex_b <= val_b;
         ex_rd <= id_rd;
         ex_wen <= id_wen;
      end else if (ex_ready) begin
         state <= EMPTY;
      end
   end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed plan plus random traffic against a behavioural pipeline model
module tb_operand_fetch;
   logic clk = 1'b0;
   logic rst;
   logic id_valid, id_ready, id_wen;
   logic [4:0] id_rs, id_rt, id_rd;
   logic ex_valid, ex_ready, ex_wen;
   logic [31:0] ex_a, ex_b;
   logic [4:0] ex_rd;
   logic wb_valid;
   logic [4:0] wb_addr;
   logic [31:0] wb_data;
   logic [4:0] rf_r1_addr, rf_r2_addr, rf_r3_addr;
   logic [31:0] rf_r1_dout, rf_r2_dout, rf_r3_din;
   logic rf_r3_wr;
   logic [31:0] busy;
   logic [31:0] rf [32];
   logic rf_load;
   int total = 0;
   int bad = 0;
   logic [31:0] m_busy;
   logic m_valid;
   logic [31:0] m_a, m_b;
   logic [4:0] m_rd;
   logic m_wen;

   always #5 clk = ~clk;

   operand_fetch #(.DW(32)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_wen(id_wen),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd), .ex_wen(ex_wen),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .rf_r1_addr(rf_r1_addr), .rf_r2_addr(rf_r2_addr),
      .rf_r1_dout(rf_r1_dout), .rf_r2_dout(rf_r2_dout),
      .rf_r3_addr(rf_r3_addr), .rf_r3_din(rf_r3_din), .rf_r3_wr(rf_r3_wr),
      .busy(busy)
   );

   assign rf_r1_dout = rf[rf_r1_addr];
   assign rf_r2_dout = rf[rf_r2_addr];

   // bench-side register file; r0 holds all-ones so zero forcing is visible
   always @(posedge clk) begin
      if (rf_load) begin
         for (int i = 0; i < 32; i++)
            rf[i] <= i == 0 ? 32'hFFFF_FFFF : i == 1 ? 32'd5 : i == 2 ? 32'd7 :
                     i == 5 ? 32'd1 : i == 6 ? 32'd2 : i * 32'h0101_0101;
      end else if (rf_r3_wr) begin
         rf[rf_r3_addr] <= rf_r3_din;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic pending(input logic [4:0] s, input logic wv, input logic [4:0] wa);
      return s != 0 && m_busy[s] && !(wv && wa == s);
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] s, input logic wv,
                                            input logic [4:0] wa, input logic [31:0] wd);
      return s == 0 ? 32'd0 : (wv && wa == s) ? wd : rf[s];
   endfunction

   task automatic step(input logic r, input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic wen, input logic er, input logic wv,
                       input logic [4:0] wa, input logic [31:0] wd);
      logic rdy, go;
      rst = r; id_valid = iv; id_rs = rs; id_rt = rt; id_rd = rd; id_wen = wen;
      ex_ready = er; wb_valid = wv; wb_addr = wa; wb_data = wd;
      #1;
      rdy = !r && !pending(rs, wv, wa) && !pending(rt, wv, wa) && !(wen && pending(rd, wv, wa))
            && (!m_valid || er);
      go = iv && rdy;
      chk("id_ready", {31'd0, id_ready}, {31'd0, rdy});
      chk("rf_r3_wr", {31'd0, rf_r3_wr}, {31'd0, wv && wa != 0});
      chk("rf_r3_din", rf_r3_din, wd);
      chk("rf_rd_addr", {17'd0, rf_r3_addr, rf_r2_addr, rf_r1_addr}, {17'd0, wa, rt, rs});
      if (r) begin
         m_busy = '0; m_valid = 1'b0; m_a = '0; m_b = '0; m_rd = '0; m_wen = 1'b0;
      end else begin
         if (wv) m_busy[wa] = 1'b0;
         if (go && wen && rd != 0) m_busy[rd] = 1'b1;
         if (go) begin
            m_a = operand(rs, wv, wa, wd);
            m_b = operand(rt, wv, wa, wd);
            m_rd = rd; m_wen = wen; m_valid = 1'b1;
         end else if (er) begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
      chk("busy", busy, m_busy);
      if (m_valid || r) begin
         chk("ex_a", ex_a, m_a);
         chk("ex_b", ex_b, m_b);
         chk("ex_rd_wen", {26'd0, ex_rd, ex_wen}, {26'd0, m_rd, m_wen});
      end
      @(negedge clk);
   endtask

   initial begin
      m_busy = '0; m_valid = 1'b0; m_a = '0; m_b = '0; m_rd = '0; m_wen = 1'b0;
      rf_load = 1'b1;
      @(negedge clk);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rf_load = 1'b0;
      step(1, 1, 1, 2, 3, 1, 1, 0, 0, 0);
      step(0, 1, 1, 2, 3, 1, 1, 0, 0, 0);
      chk("ind_ab0", {ex_a[15:0], ex_b[15:0]}, {16'd5, 16'd7});
      step(0, 1, 5, 6, 4, 1, 1, 0, 0, 0);
      chk("ind_ab1", {ex_a[15:0], ex_b[15:0]}, {16'd1, 16'd2});
      chk("ind_busy", busy & 32'h18, 32'h18);
      for (int i = 0; i < 3; i++) step(0, 1, 3, 0, 7, 1, 1, 0, 0, 0);
      chk("raw_stall", {31'd0, ex_valid}, 32'd0);
      step(0, 1, 3, 0, 7, 1, 1, 1, 3, 32'hDEAD);
      chk("raw_fwd", ex_a, 32'hDEAD);
      chk("raw_clr", {31'd0, busy[3]}, 32'd0);
      step(0, 1, 0, 0, 0, 0, 1, 1, 0, 32'h1234);
      chk("zero_a", ex_a, 32'd0);
      step(0, 1, 1, 2, 9, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 5, 6, 10, 1, 0, 0, 0, 0);
      chk("bp_hold", {27'd0, ex_rd}, 32'd9);
      step(0, 1, 5, 6, 10, 1, 1, 0, 0, 0);
      chk("bp_next", {27'd0, ex_rd}, 32'd10);
      step(0, 1, 0, 0, 8, 1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 8, 1, 1, 1, 8, 32'h55);
      chk("waw_set", {31'd0, busy[8]}, 32'd1);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("rst_busy", busy, 32'd0);
      for (int n = 0; n < 3000; n++)
         step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
              5'($urandom_range(0, 7)), $urandom);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
